// File: rtl/servo_pwm_if.sv
// servo_pwm_if: angle command in, servo pulse / frame tick / applied angle out.
interface servo_pwm_if;
    logic [7:0] rotate_angle;
    logic       pwm_out;
    logic       frame_tick;
    logic [7:0] angle_now;
    modport master (output rotate_angle, input pwm_out, frame_tick, angle_now);
    modport slave (input rotate_angle, output pwm_out, frame_tick, angle_now);
endinterface

// File: rtl/servo_pwm.sv
// servo_pwm: fixed-period servo pulse generator; angle is sampled only at frame wrap.
// Define SERVO_SLEW_EN to limit the applied angle to SLEW_DEG degrees of movement per frame.
module servo_pwm #(
    parameter int PERIOD_CYC = 240000,
    parameter int MIN_CYC    = 6000,
    parameter int STEP_CYC   = 133,
    parameter int SLEW_DEG   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    servo_pwm_if.slave bus_io
);
    if (MIN_CYC + 180 * STEP_CYC >= PERIOD_CYC || PERIOD_CYC > 2 ** 18 || SLEW_DEG < 1) begin : g_bad_cfg
        $error("servo_pwm: illegal parameter set");
    end
    logic [17:0] cnt_q, cnt_d;
    logic [7:0]  cur_q, cur_d, tgt, nxt;
    logic        pwm_q, pwm_d, tick_q, tick_d, wrap;
    logic [14:0] pw;
    assign wrap = cnt_q == 18'(PERIOD_CYC - 1);
    assign tgt  = bus_io.rotate_angle > 8'd180 ? 8'd180 : bus_io.rotate_angle;
    assign pw   = 15'(MIN_CYC) + 15'(cur_q) * 15'(STEP_CYC);
`ifdef SERVO_SLEW_EN
    logic [8:0] up, dn;
    assign up  = {1'b0, cur_q} + 9'(SLEW_DEG);
    // Saturate at zero so the max() against the target never sees a wrapped value
    assign dn  = {1'b0, cur_q} > 9'(SLEW_DEG) ? {1'b0, cur_q} - 9'(SLEW_DEG) : 9'd0;
    assign nxt = tgt > cur_q ? (up < {1'b0, tgt} ? up[7:0] : tgt) :
                 tgt < cur_q ? (dn > {1'b0, tgt} ? dn[7:0] : tgt) : cur_q;
`else
    assign nxt = tgt;
`endif
    always_comb begin
        cnt_d  = wrap ? 18'd0 : cnt_q + 18'd1;
        cur_d  = wrap ? nxt : cur_q;
        pwm_d  = cnt_q < {3'b000, pw};
        tick_d = wrap;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 18'd0;
            cur_q  <= 8'd90;
            pwm_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            cur_q  <= cur_d;
            pwm_q  <= pwm_d;
            tick_q <= tick_d;
        end
    end
    assign bus_io.pwm_out    = pwm_q;
    assign bus_io.frame_tick = tick_q;
    assign bus_io.angle_now  = cur_q;
endmodule
